// File: rtl/semaforo_ctrl_pkg.sv
// Shared types, lamp encodings and width helpers for the traffic-light sequencer.
package semaforo_ctrl_pkg;

   typedef enum logic [1:0] {
      S_VERDE,
      S_AMBAR,
      S_ROJO,
      S_INTERMIT
   } fase_e;

   // Car lamps are one-hot {rojo, ambar, verde}
   localparam logic [2:0] COCHE_OFF    = 3'b000;
   localparam logic [2:0] COCHE_VERDE  = 3'b001;
   localparam logic [2:0] COCHE_AMBAR  = 3'b010;
   localparam logic [2:0] COCHE_ROJO   = 3'b100;

   // Pedestrian lamps are one-hot {verde, rojo}
   localparam logic [1:0] PEATON_OFF   = 2'b00;
   localparam logic [1:0] PEATON_ROJO  = 2'b01;
   localparam logic [1:0] PEATON_VERDE = 2'b10;

   // Bits needed to hold 0..value-1, never less than one
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
         res = res + 1;
      end
      return (res == 0) ? 1 : res;
   endfunction

   function automatic int unsigned max_dur(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Counter width for the default phase lengths
   localparam int unsigned DEF_WIDTH = clogb2(max_dur(20, 5, 4, 16));

endpackage

// File: rtl/semaforo_ctrl_if.sv
// Strobe/request inputs and lamp/status outputs of the sequencer.
interface semaforo_ctrl_if
   import semaforo_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) ();

   logic             tick_en;
   logic             ped_req;
   logic             averia;
   logic [2:0]       luz_coche;
   logic [1:0]       luz_peaton;
   logic             ped_ack;
   logic [WIDTH-1:0] phase_count;
   logic             phase_tc;

   modport master (
      output tick_en, ped_req, averia,
      input  luz_coche, luz_peaton, ped_ack, phase_count, phase_tc
   );

   modport slave (
      input  tick_en, ped_req, averia,
      output luz_coche, luz_peaton, ped_ack, phase_count, phase_tc
   );

endinterface

// File: rtl/semaforo_ctrl_fase_timer.sv
// Modulo phase counter: advances on tick_en, wraps at len-1, clr wins over counting.
module fase_timer
   import semaforo_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tick_en,
   input  logic             clr,
   input  logic [WIDTH:0]   len,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             at_end;

   // Next count: clear, wrap at terminal count, or step on the strobe
   always_comb begin
      at_end  = ({1'b0, count_q} == (len - 1'b1));
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (tick_en) begin
         count_d = at_end ? '0 : count_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc    = at_end;

endmodule

// File: rtl/semaforo_ctrl.sv
// Traffic-light sequencer: green/amber/red phases, pedestrian early exit, blinking fault mode.
module semaforo_ctrl
   import semaforo_ctrl_pkg::*;
#(
   parameter int unsigned T_VERDE     = 20,
   parameter int unsigned T_MIN_VERDE = 5,
   parameter int unsigned T_AMBAR     = 4,
   parameter int unsigned T_ROJO      = 16
) (
   input logic            clock,
   input logic            reset,
   semaforo_ctrl_if.slave bus
);

   localparam int unsigned WIDTH = clogb2(max_dur(T_VERDE, T_MIN_VERDE, T_AMBAR, T_ROJO));
   localparam int unsigned LW    = WIDTH + 1;

   localparam logic [WIDTH:0] LEN_VERDE = LW'(T_VERDE);
   localparam logic [WIDTH:0] LEN_MIN   = LW'(T_MIN_VERDE);
   localparam logic [WIDTH:0] LEN_AMBAR = LW'(T_AMBAR);
   localparam logic [WIDTH:0] LEN_ROJO  = LW'(T_ROJO);
   localparam logic [WIDTH:0] MIN_M1    = LW'(T_MIN_VERDE - 1);

   fase_e            state_q, state_d;
   logic             pending_q, pending_d;
   logic             blink_q, blink_d;
   logic             ped_ack_q, ped_ack_d;
   logic [2:0]       luz_coche_q, luz_coche_d;
   logic [1:0]       luz_peaton_q, luz_peaton_d;

   logic [WIDTH:0]   len;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             clr;
   logic             early_exit;
   logic             phase_end;

   // Phase length seen by the timer; a pending request shortens green
   always_comb begin
      case (state_q)
         S_VERDE: len = pending_q ? LEN_MIN : LEN_VERDE;
         S_AMBAR: len = LEN_AMBAR;
         default: len = LEN_ROJO;
      endcase
   end

   fase_timer #(
      .WIDTH(WIDTH)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .tick_en(bus.tick_en),
      .clr    (clr),
      .len    (len),
      .count  (count),
      .tc     (tc)
   );

   // Next state, request latch, blink and lamp decode of the next state
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      blink_d    = blink_q;
      ped_ack_d  = 1'b0;
      clr        = 1'b0;
      // A request latched late in green leaves count above the shortened
      // length, so the exit is a >= test rather than the timer's wrap.
      early_exit = (state_q == S_VERDE) && pending_q && ({1'b0, count} >= MIN_M1);
      phase_end  = bus.tick_en && (tc || early_exit);

      if (bus.averia) begin
         state_d   = S_INTERMIT;
         clr       = 1'b1;
         pending_d = 1'b0;
         blink_d   = (state_q == S_INTERMIT) ? (blink_q ^ bus.tick_en) : 1'b1;
      end else if (state_q == S_INTERMIT) begin
         state_d = S_ROJO;
         clr     = 1'b1;
         blink_d = 1'b0;
      end else begin
         if (bus.ped_req && (state_q != S_ROJO)) begin
            pending_d = 1'b1;
         end
         if (phase_end) begin
            clr = 1'b1;
            case (state_q)
               S_VERDE: state_d = S_AMBAR;
               S_AMBAR: begin
                  state_d   = S_ROJO;
                  ped_ack_d = pending_q | bus.ped_req;
                  pending_d = 1'b0;
               end
               default: state_d = S_VERDE;
            endcase
         end
      end

      case (state_d)
         S_VERDE: begin
            luz_coche_d  = COCHE_VERDE;
            luz_peaton_d = PEATON_ROJO;
         end
         S_AMBAR: begin
            luz_coche_d  = COCHE_AMBAR;
            luz_peaton_d = PEATON_ROJO;
         end
         S_ROJO: begin
            luz_coche_d  = COCHE_ROJO;
            luz_peaton_d = PEATON_VERDE;
         end
         default: begin
            luz_coche_d  = blink_d ? COCHE_AMBAR : COCHE_OFF;
            luz_peaton_d = PEATON_OFF;
         end
      endcase
   end

   // FSM and registered lamp outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_VERDE;
         pending_q    <= 1'b0;
         blink_q      <= 1'b0;
         ped_ack_q    <= 1'b0;
         luz_coche_q  <= COCHE_VERDE;
         luz_peaton_q <= PEATON_ROJO;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         blink_q      <= blink_d;
         ped_ack_q    <= ped_ack_d;
         luz_coche_q  <= luz_coche_d;
         luz_peaton_q <= luz_peaton_d;
      end
   end

   assign bus.luz_coche   = luz_coche_q;
   assign bus.luz_peaton  = luz_peaton_q;
   assign bus.ped_ack     = ped_ack_q;
   assign bus.phase_count = count;
   assign bus.phase_tc    = tc && (state_q != S_INTERMIT);

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Bench for semaforo_ctrl: directed scenarios plus random traffic against a phase-budget model.
module tb_semaforo_ctrl;

   localparam int T_VERDE     = 20;
   localparam int T_MIN_VERDE = 5;
   localparam int T_AMBAR     = 4;
   localparam int T_ROJO      = 16;

   logic clock;
   logic reset;

   semaforo_ctrl_if bus ();

   semaforo_ctrl #(
      .T_VERDE    (T_VERDE),
      .T_MIN_VERDE(T_MIN_VERDE),
      .T_AMBAR    (T_AMBAR),
      .T_ROJO     (T_ROJO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   int n_acks   = 0;
   bit chk_en   = 1'b0;

   // Model: phase index 0=green 1=amber 2=red 3=fault, ticks used in phase
   int m_phase = 0;
   int m_cnt   = 0;
   bit m_pend  = 1'b0;
   bit m_blink = 1'b0;
   bit m_ack   = 1'b0;
   int dur [3] = '{T_VERDE, T_AMBAR, T_ROJO};

   function automatic int budget(input int ph, input bit pend);
      if (ph == 0 && pend) return T_MIN_VERDE;
      return dur[ph];
   endfunction

   always @(posedge clock) begin
      int lim;
      bit req;
      if (reset) begin
         m_phase = 0; m_cnt = 0; m_pend = 0; m_blink = 0; m_ack = 0;
      end else if (bus.averia) begin
         m_blink = (m_phase == 3) ? (m_blink ^ bus.tick_en) : 1'b1;
         m_phase = 3; m_cnt = 0; m_pend = 0; m_ack = 0;
      end else if (m_phase == 3) begin
         m_phase = 2; m_cnt = 0; m_ack = 0; m_blink = 0;
      end else begin
         m_ack = 0;
         lim = budget(m_phase, m_pend);
         req = bus.ped_req && (m_phase < 2);
         if (bus.tick_en && (m_cnt + 1 >= lim)) begin
            if (m_phase == 1) begin
               m_ack  = m_pend || req;
               m_pend = 0;
               req    = 0;
            end
            m_phase = (m_phase + 1) % 3;
            m_cnt   = 0;
         end else if (bus.tick_en) begin
            m_cnt = m_cnt + 1;
         end
         if (req) m_pend = 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      logic [2:0] e_coche;
      logic [1:0] e_peat;
      logic       e_tc;
      if (bus.ped_ack === 1'b1) n_acks++;
      if (chk_en) begin
         case (m_phase)
            0: begin e_coche = 3'b001; e_peat = 2'b01; end
            1: begin e_coche = 3'b010; e_peat = 2'b01; end
            2: begin e_coche = 3'b100; e_peat = 2'b10; end
            default: begin e_coche = m_blink ? 3'b010 : 3'b000; e_peat = 2'b00; end
         endcase
         e_tc = (m_phase != 3) && (m_cnt == budget(m_phase, m_pend) - 1);
         chk("model_luz_coche", 32'(bus.luz_coche), 32'(e_coche));
         chk("model_luz_peaton", 32'(bus.luz_peaton), 32'(e_peat));
         chk("model_ped_ack", 32'(bus.ped_ack), 32'(m_ack));
         chk("model_phase_count", 32'(bus.phase_count), 32'(m_cnt));
         chk("model_phase_tc", 32'(bus.phase_tc), 32'(e_tc));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      int a0;
      int n_amb;
      reset = 1'b1;
      bus.tick_en = 1'b0;
      bus.ped_req = 1'b0;
      bus.averia  = 1'b0;
      step(1);
      chk_en = 1'b1;
      chk("rst_coche", 32'(bus.luz_coche), 32'h1);
      chk("rst_peaton", 32'(bus.luz_peaton), 32'h1);
      chk("rst_count", 32'(bus.phase_count), 32'h0);
      chk("rst_ack", 32'(bus.ped_ack), 32'h0);

      // Free-running cycle, tick every clock
      reset = 1'b0;
      bus.tick_en = 1'b1;
      a0 = n_acks;
      step(19);
      chk("green_tc19", 32'(bus.phase_tc), 32'h1);
      chk("green_cnt19", 32'(bus.phase_count), 32'd19);
      step(1);
      chk("amber_entry", 32'(bus.luz_coche), 32'h2);
      step(3);
      chk("amber_tc3", 32'(bus.phase_tc), 32'h1);
      step(1);
      chk("red_entry", 32'(bus.luz_coche), 32'h4);
      step(15);
      chk("red_tc15", 32'(bus.phase_tc), 32'h1);
      step(1);
      chk("green_again", 32'(bus.luz_coche), 32'h1);
      chk("no_ack_free", 32'(n_acks - a0), 32'h0);

      // Request at green count 2 cuts green to 5 ticks
      step(2);
      bus.ped_req = 1'b1;
      step(1);
      bus.ped_req = 1'b0;
      step(1);
      chk("early_cnt4_green", 32'(bus.luz_coche), 32'h1);
      chk("early_tc4", 32'(bus.phase_tc), 32'h1);
      step(1);
      chk("early_amber", 32'(bus.luz_coche), 32'h2);
      step(4);
      chk("served_ack", 32'(bus.ped_ack), 32'h1);
      chk("served_peaton", 32'(bus.luz_peaton), 32'h2);
      step(1);
      chk("served_ack_drop", 32'(bus.ped_ack), 32'h0);

      // Request held across amber->red gives one ack; red ignores it
      step(15);
      step(20);
      a0 = n_acks;
      bus.ped_req = 1'b1;
      step(4);
      chk("held_ack", 32'(bus.ped_ack), 32'h1);
      step(15);
      bus.ped_req = 1'b0;
      step(1);
      chk("held_green", 32'(bus.luz_coche), 32'h1);
      step(19);
      chk("held_full_green", 32'(bus.phase_count), 32'd19);
      step(1);
      chk("held_amber", 32'(bus.luz_coche), 32'h2);
      chk("held_one_ack", 32'(n_acks - a0), 32'h1);

      // Tick every third cycle stretches amber to 12 cycles
      n_amb = 1;
      for (int k = 1; k <= 100; k++) begin
         bus.tick_en = (k % 3 == 0);
         step(1);
         if (bus.luz_coche == 3'b010) n_amb++;
         else break;
      end
      chk("slow_amber_len", 32'(n_amb), 32'd12);
      bus.tick_en = 1'b1;

      // Fault at amber count 2, then safe restart in red
      step(16);
      step(20);
      chk("fault_pre_amber", 32'(bus.luz_coche), 32'h2);
      step(2);
      chk("fault_pre_cnt", 32'(bus.phase_count), 32'h2);
      a0 = n_acks;
      bus.averia = 1'b1;
      step(1);
      chk("fault_coche_on", 32'(bus.luz_coche), 32'h2);
      chk("fault_peaton", 32'(bus.luz_peaton), 32'h0);
      chk("fault_tc", 32'(bus.phase_tc), 32'h0);
      step(1);
      chk("fault_coche_off", 32'(bus.luz_coche), 32'h0);
      step(1);
      chk("fault_coche_on2", 32'(bus.luz_coche), 32'h2);
      bus.averia = 1'b0;
      step(1);
      chk("restart_red", 32'(bus.luz_coche), 32'h4);
      chk("restart_cnt", 32'(bus.phase_count), 32'h0);
      step(15);
      chk("restart_tc", 32'(bus.phase_tc), 32'h1);
      step(1);
      chk("restart_green", 32'(bus.luz_coche), 32'h1);
      chk("fault_no_ack", 32'(n_acks - a0), 32'h0);

      // Reset mid-red with a request asserted
      step(24);
      step(7);
      chk("pre_rst_cnt", 32'(bus.phase_count), 32'd7);
      reset = 1'b1;
      bus.ped_req = 1'b1;
      step(1);
      chk("mid_rst_coche", 32'(bus.luz_coche), 32'h1);
      chk("mid_rst_cnt", 32'(bus.phase_count), 32'h0);
      chk("mid_rst_ack", 32'(bus.ped_ack), 32'h0);
      reset = 1'b0;
      bus.ped_req = 1'b0;
      step(19);
      chk("post_rst_full_green", 32'(bus.luz_coche), 32'h1);
      step(1);
      chk("post_rst_amber", 32'(bus.luz_coche), 32'h2);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         bus.tick_en = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 9) == 0) bus.ped_req = ~bus.ped_req;
         if (bus.averia) bus.averia = ($urandom_range(0, 3) != 0);
         else bus.averia = ($urandom_range(0, 149) == 0);
         step(1);
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
